// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and helpers for the multi-port decode register file.
package reg_file_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;
  localparam int REG_ZERO   = 0;

  // Keep a 1-bit id even for a single-entry file so port slices stay legal.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Read, write and issue signals of reg_file_mp; master drives ids/data, slave is the file.
interface reg_file_mp_if
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
) ();
  localparam int ADDR_W = addr_w(DEPTH);

  logic [NUM_RD*ADDR_W-1:0] rd_id;
  logic [NUM_RD*DATA_W-1:0] rd_value;
  logic [NUM_RD-1:0]        rd_pending;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_id;
  logic [NUM_WR*DATA_W-1:0] wr_value;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_id;
  logic                     any_pending;

  modport master (
    output rd_id, wr_en, wr_id, wr_value, issue_en, issue_id,
    input  rd_value, rd_pending, any_pending
  );

  modport slave (
    input  rd_id, wr_en, wr_id, wr_value, issue_en, issue_id,
    output rd_value, rd_pending, any_pending
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: cleared by accepted writebacks, set by issue (issue wins on collision).
module reg_scoreboard #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_WR = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_WR-1:0]              wr_clr_i,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_id_i,
  input  logic                           issue_set_i,
  input  logic [ADDR_W-1:0]              issue_id_i,
  output logic [DEPTH-1:0]               pend_o
);

  logic [DEPTH-1:0] pend_q, pend_d;

  // Callers only assert clr/set for in-range, non-zero-register ids.
  always_comb begin
    pend_d = pend_q;
    for (int w = 0; w < NUM_WR; w++)
      if (wr_clr_i[w]) pend_d[wr_id_i[w]] = 1'b0;
    if (issue_set_i) pend_d[issue_id_i] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) pend_q <= '0;
    else          pend_q <= pend_d;

  assign pend_o = pend_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with pending scoreboard. Optional same-cycle write-to-read
// forwarding is enabled by defining REG_FILE_MP_BYPASS_EN.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter int ZERO_REG = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  reg_file_mp_if.slave rf
);

  localparam int                ADDR_W  = addr_w(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_ID = ADDR_W'(REG_ZERO);

  // An id is usable when it addresses a real register that is not the hardwired zero.
  function automatic logic id_ok(input logic [ADDR_W-1:0] id);
    return ({1'b0, id} < DEPTH_L) && !((ZERO_REG != 0) && (id == ZERO_ID));
  endfunction

  logic [DEPTH-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic [NUM_WR-1:0][ADDR_W-1:0] wr_id_a;
  logic [NUM_WR-1:0][DATA_W-1:0] wr_val_a;
  logic [NUM_WR-1:0]             wr_ok;
  logic                          issue_ok;
  logic [DEPTH-1:0]              pend;

  assign wr_id_a  = rf.wr_id;
  assign wr_val_a = rf.wr_value;
  assign issue_ok = rf.issue_en && id_ok(rf.issue_id);

  always_comb begin
    for (int w = 0; w < NUM_WR; w++)
      wr_ok[w] = rf.wr_en[w] && id_ok(wr_id_a[w]);
  end

  // Later ports overwrite earlier ones, so the highest port index wins.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NUM_WR; w++)
      if (wr_ok[w]) regs_d[wr_id_a[w]] = wr_val_a[w];
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) regs_q <= '0;
    else          regs_q <= regs_d;

  reg_scoreboard #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_sb (
    .clock       (clock),
    .reset_n     (reset_n),
    .wr_clr_i    (wr_ok),
    .wr_id_i     (wr_id_a),
    .issue_set_i (issue_ok),
    .issue_id_i  (rf.issue_id),
    .pend_o      (pend)
  );

  assign rf.any_pending = |pend;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] id;
    logic [DATA_W-1:0] val;
    logic              pnd;

    assign id = rf.rd_id[p*ADDR_W +: ADDR_W];

    always_comb begin
      val = '0;
      pnd = 1'b0;
      if (id_ok(id)) begin
        val = regs_q[id];
        pnd = pend[id];
      end
`ifdef REG_FILE_MP_BYPASS_EN
      // wr_ok already excludes register 0 and out-of-range ids.
      for (int w = 0; w < NUM_WR; w++)
        if (wr_ok[w] && (wr_id_a[w] == id)) begin
          val = wr_val_a[w];
          pnd = 1'b0;
        end
`else
`endif
    end

    assign rf.rd_value[p*DATA_W +: DATA_W] = val;
    assign rf.rd_pending[p]                = pnd;
  end

endmodule
